vu_meter_peak_hold: RTL and testbench

Parametrised N-LED VU meter with peak-hold indicator and clip detection, driven by the I2S capture block's per-sample strobe.
- Channel source selectable: left, right, or the louder of the two.
- Envelope uses instant attack and exponential decay.
- LED thresholds are spaced 6 dB apart.
- A peak-hold dot holds for a set time, then falls one LED per display tick.
- Sits between the I2S capture block and the board LED pins.

---
 rtl/vu_meter_peak_hold.sv | 142 ++++++++++++++
 tb/tb_vu_meter_peak_hold.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vu_meter_peak_hold.sv
// rtl/vu_meter_peak_hold.sv - N-LED VU meter with peak-hold dot and sticky clip detect
module vu_meter_peak_hold #(
   parameter int DATA_W       = 16,
   parameter int NUM_LEDS     = 8,
   parameter int CHANNEL_MODE = 2,
   parameter int DECAY_SHIFT  = 11,
   parameter int TH_BASE      = 64,
   parameter int CLIP_TH      = 2**(DATA_W-1)-2,
   parameter int LED_DIV      = 540000,
   parameter int HOLD_TICKS   = 25
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sample_stb_i,
   input  logic [DATA_W-1:0]   left_sample_i,
   input  logic [DATA_W-1:0]   right_sample_i,
   input  logic                bar_mode_i,
   input  logic                clip_clr_i,
   output logic [NUM_LEDS-1:0] leds_o,
   output logic                clip_o,
   output logic                tick_o
);

   localparam int MW = DATA_W - 1;
   localparam int LW = MW + DECAY_SHIFT;
   localparam int CW = $clog2(NUM_LEDS + 1);
   localparam int DW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [MW-1:0] MAG_MAX = '1;

   if ((TH_BASE << (NUM_LEDS - 1)) > (2**(DATA_W-1) - 1)) begin : g_bad_threshold
      $error("TH_BASE << (NUM_LEDS-1) exceeds the largest sample magnitude");
   end

   // The most negative sample negates onto itself; it saturates to full scale.
   function automatic logic [MW-1:0] abs_sat(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] n;
      n = ~s + DATA_W'(1);
      if (!s[DATA_W-1])
         return s[MW-1:0];
      else if (n[DATA_W-1])
         return MAG_MAX;
      else
         return n[MW-1:0];
   endfunction

   logic [MW-1:0]       mag_l;
   logic [MW-1:0]       mag_r;
   logic [MW-1:0]       mag;
   logic [LW-1:0]       level_q;
   logic [LW-1:0]       attack;
   logic [LW-1:0]       decayed;
   logic [MW-1:0]       env;
   logic [CW-1:0]       cur;
   logic [DW-1:0]       div_q;
   logic                tick_now;
   logic [CW-1:0]       peak_q;
   logic [HW-1:0]       hold_q;
   logic [NUM_LEDS-1:0] leds_nxt;

   always_comb begin
      mag_l = abs_sat(left_sample_i);
      mag_r = abs_sat(right_sample_i);
      if (CHANNEL_MODE == 0)
         mag = mag_l;
      else if (CHANNEL_MODE == 1)
         mag = mag_r;
      else
         mag = (mag_l > mag_r) ? mag_l : mag_r;
   end

   assign attack  = LW'(mag) << DECAY_SHIFT;
   assign decayed = level_q - (level_q >> DECAY_SHIFT);
   assign env     = MW'(level_q >> DECAY_SHIFT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         level_q <= '0;
      else if (sample_stb_i)
         level_q <= (attack > level_q) ? attack : decayed;
   end

   // Thresholds double per LED, so the count of passed thresholds is the bar height.
   always_comb begin
      cur = '0;
      for (int k = 0; k < NUM_LEDS; k++) begin
         if (32'(env) >= 32'(TH_BASE << k))
            cur = cur + CW'(1);
      end
   end

   assign tick_now = (div_q == DW'(LED_DIV - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         tick_o <= tick_now;
         div_q  <= tick_now ? '0 : div_q + DW'(1);
      end
   end

   always_comb begin
      leds_nxt = '0;
      for (int k = 0; k < NUM_LEDS; k++) begin
         if (bar_mode_i ? (k < int'(cur)) : (k == int'(cur) - 1))
            leds_nxt[k] = 1'b1;
         if (k == int'(peak_q) - 1)
            leds_nxt[k] = 1'b1;
      end
   end

   // leds_nxt is built from the peak before this tick's update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         peak_q <= '0;
         hold_q <= '0;
         leds_o <= '0;
      end else if (tick_now) begin
         leds_o <= leds_nxt;
         if (cur >= peak_q) begin
            peak_q <= cur;
            hold_q <= HW'(HOLD_TICKS);
         end else if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
         end else begin
            peak_q <= peak_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         clip_o <= 1'b0;
      else if (sample_stb_i && (32'(mag) >= 32'(CLIP_TH)))
         clip_o <= 1'b1;
      else if (clip_clr_i)
         clip_o <= 1'b0;
   end

endmodule

// File: tb/tb_vu_meter_peak_hold.sv
// tb/tb_vu_meter_peak_hold.sv - directed self-checking bench for vu_meter_peak_hold
module tb_vu_meter_peak_hold;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        bar = 1'b1;
   logic        clr = 1'b0;
   logic [15:0] left = '0;
   logic [15:0] right = '0;

   logic [7:0]  leds0, leds1, leds2, ledsp;
   logic        clip0, clip1, clip2, clipp;
   logic        tick0, tick1, tick2, tickp;

   int total = 0;
   int bad = 0;
   int lvl;
   int n;
   logic [7:0] ph_exp [10] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h10,
                               8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

   always #5 clk = ~clk;

   vu_meter_peak_hold #(.CHANNEL_MODE(0), .DECAY_SHIFT(4), .LED_DIV(16), .HOLD_TICKS(3)) u_m0 (
      .clk_i(clk), .rst_i(rst), .sample_stb_i(stb), .left_sample_i(left), .right_sample_i(right),
      .bar_mode_i(bar), .clip_clr_i(clr), .leds_o(leds0), .clip_o(clip0), .tick_o(tick0));

   vu_meter_peak_hold #(.CHANNEL_MODE(1), .DECAY_SHIFT(4), .LED_DIV(16), .HOLD_TICKS(3)) u_m1 (
      .clk_i(clk), .rst_i(rst), .sample_stb_i(stb), .left_sample_i(left), .right_sample_i(right),
      .bar_mode_i(bar), .clip_clr_i(clr), .leds_o(leds1), .clip_o(clip1), .tick_o(tick1));

   vu_meter_peak_hold #(.CHANNEL_MODE(2), .DECAY_SHIFT(4), .LED_DIV(16), .HOLD_TICKS(3)) u_m2 (
      .clk_i(clk), .rst_i(rst), .sample_stb_i(stb), .left_sample_i(left), .right_sample_i(right),
      .bar_mode_i(bar), .clip_clr_i(clr), .leds_o(leds2), .clip_o(clip2), .tick_o(tick2));

   // Fast decay so the bar drops to zero well inside one display tick.
   vu_meter_peak_hold #(.CHANNEL_MODE(2), .DECAY_SHIFT(1), .LED_DIV(16), .HOLD_TICKS(3)) u_ph (
      .clk_i(clk), .rst_i(rst), .sample_stb_i(stb), .left_sample_i(left), .right_sample_i(right),
      .bar_mode_i(bar), .clip_clr_i(clr), .leds_o(ledsp), .clip_o(clipp), .tick_o(tickp));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stb = 1'b0; clr = 1'b0; left = '0; right = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic strobe(input logic [15:0] l, input logic [15:0] r);
      @(negedge clk);
      left = l; right = r; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
   endtask

   task automatic wait_tick();
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!tick2 && cnt < 40);
      check_eq("tick_seen", {31'b0, tick2}, 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_leds0", leds0, 0); check_eq("rst_clip0", clip0, 0); check_eq("rst_tick0", tick0, 0);
      check_eq("rst_leds1", leds1, 0); check_eq("rst_clip1", clip1, 0); check_eq("rst_tick1", tick1, 0);
      check_eq("rst_leds2", leds2, 0); check_eq("rst_clip2", clip2, 0); check_eq("rst_tick2", tick2, 0);
      check_eq("rst_ledsp", ledsp, 0); check_eq("rst_clipp", clipp, 0); check_eq("rst_tickp", tickp, 0);

      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick2 && n < 40);
      check_eq("first_tick_cycles", n, 16);
      @(negedge clk);
      check_eq("tick_one_cycle", {31'b0, tick2}, 0);

      do_reset(); bar = 1'b1; strobe(16'd300, 16'd0); wait_tick();
      check_eq("attack_bar_300", leds2, 8'h07);

      do_reset(); bar = 1'b0; strobe(16'd300, 16'd0); wait_tick();
      check_eq("attack_dot_300", leds2, 8'h04);
      bar = 1'b1;

      do_reset(); strobe(16'h8000, 16'd0); wait_tick();
      check_eq("full_scale_leds", leds2, 8'hFF);
      check_eq("full_scale_clip", {31'b0, clip2}, 1);

      @(posedge clk); #2 rst = 1'b1; #1;
      check_eq("async_rst_leds", leds2, 0);
      check_eq("async_rst_clip", {31'b0, clip2}, 0);
      check_eq("async_rst_tick", {31'b0, tick2}, 0);
      @(negedge clk); rst = 1'b0;

      do_reset(); strobe(16'd100, 16'hEC78); wait_tick();
      check_eq("chan_left", leds0, 8'h01);
      check_eq("chan_right", leds1, 8'h7F);
      check_eq("chan_max", leds2, 8'h7F);

      do_reset(); strobe(16'h8000, 16'd0);
      lvl = 32767 << 4;
      for (int i = 0; i < 300; i++) begin
         strobe(16'd0, 16'd0);
         lvl = lvl - (lvl >> 4);
         check_eq("decay_env", 32'(u_m2.env), lvl >> 4);
      end
      check_eq("decay_floor", 32'(u_m2.env), 0);
      wait_tick();
      check_eq("decay_leds_off", leds2, 0);

      do_reset(); bar = 1'b1; strobe(16'd3000, 16'd0); wait_tick();
      check_eq("peak_burst", ledsp, 8'h3F);
      @(negedge clk); left = '0; right = '0; stb = 1'b1;
      repeat (10) @(negedge clk);
      stb = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_tick();
         check_eq($sformatf("peak_tick%0d", i + 2), ledsp, ph_exp[i]);
      end

      do_reset();
      strobe(16'd32765, 16'd0);
      check_eq("clip_below_th", {31'b0, clip2}, 0);
      strobe(16'd32766, 16'd0);
      check_eq("clip_at_th", {31'b0, clip2}, 1);
      wait_tick(); wait_tick();
      check_eq("clip_sticky", {31'b0, clip2}, 1);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      check_eq("clip_cleared", {31'b0, clip2}, 0);
      @(negedge clk); left = 16'h8001; stb = 1'b1; clr = 1'b1;
      @(negedge clk); stb = 1'b0; clr = 1'b0;
      check_eq("clip_set_wins", {31'b0, clip2}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
